dmg_timer: RTL and testbench

//  DMG divider/timer: 16-bit free-running divider (DIV = upper byte), TIMA counter clocked by
//  a selectable divider tap, TMA reload with delayed overflow, and a one-cycle timer IRQ

---
 rtl/dmg_timer.sv | 133 +++++++++++++
 tb/tb_dmg_timer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmg_timer.sv
`default_nettype none
// ============================================================================
// Module  : dmg_timer
// Brief   : DMG divider, TIMA/TMA/TAC timer with delayed reload and IRQ pulse
// Revision: 1.0 - initial release
// ============================================================================
module dmg_timer #(
   parameter int DIV_WIDTH    = 16,
   parameter int RELOAD_DELAY = 4,
   parameter int INITIAL_DIV  = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr,
   input  logic [1:0] addr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       irq_timer
);

   localparam int CNT_W = (RELOAD_DELAY < 2) ? 1 : $clog2(RELOAD_DELAY + 1);
   localparam logic [CNT_W-1:0]     c_reload   = CNT_W'(RELOAD_DELAY);
   localparam logic [CNT_W-1:0]     c_cnt_one  = CNT_W'(1);
   localparam logic [DIV_WIDTH-1:0] c_init_div = DIV_WIDTH'(INITIAL_DIV);
   localparam logic [1:0] c_addr_div  = 2'd0;
   localparam logic [1:0] c_addr_tima = 2'd1;
   localparam logic [1:0] c_addr_tma  = 2'd2;
   localparam logic [1:0] c_addr_tac  = 2'd3;

   logic [DIV_WIDTH-1:0] r_div;
   logic [7:0]           r_tima;
   logic [7:0]           r_tma;
   logic [2:0]           r_tac;
   logic                 r_edge;
   logic [CNT_W-1:0]     r_count;
   logic                 r_irq;

   logic                 w_wr_div;
   logic                 w_wr_tima;
   logic                 w_wr_tma;
   logic                 w_wr_tac;
   logic                 w_tap;
   logic                 w_sig;
   logic                 w_tick;
   logic                 w_reload;
   logic [7:0]           w_tma_next;
   logic [7:0]           w_tima_next;
   logic [CNT_W-1:0]     w_count_next;
   logic                 w_irq_next;
   logic [7:0]           w_div_hi;

   assign w_wr_div  = wr && (addr == c_addr_div);
   assign w_wr_tima = wr && (addr == c_addr_tima);
   assign w_wr_tma  = wr && (addr == c_addr_tma);
   assign w_wr_tac  = wr && (addr == c_addr_tac);

   // DIV always exposes bits [15:8]; narrow dividers read back zero-padded.
   generate
      if (DIV_WIDTH >= 16) begin : g_div_wide
         assign w_div_hi = r_div[15:8];
      end else begin : g_div_narrow
         assign w_div_hi = {{(16-DIV_WIDTH){1'b0}}, r_div[DIV_WIDTH-1:8]};
      end
   endgenerate

   always_comb begin
      w_tap = 1'b0;
      case (r_tac[1:0])
         2'b00:   w_tap = r_div[9];
         2'b01:   w_tap = r_div[3];
         2'b10:   w_tap = r_div[5];
         default: w_tap = r_div[7];
      endcase
   end

   // Falling edge of the gated tap; DIV/TAC writes can fabricate a tick.
   assign w_sig      = r_tac[2] & w_tap;
   assign w_tick     = r_edge & ~w_sig;
   assign w_reload   = (r_count == c_cnt_one);
   assign w_tma_next = w_wr_tma ? wdata : r_tma;

   always_comb begin
      w_tima_next  = r_tima;
      w_count_next = (r_count != '0) ? (r_count - c_cnt_one) : '0;
      w_irq_next   = 1'b0;
      if (w_reload) begin
         w_tima_next = w_tma_next;
         w_irq_next  = 1'b1;
      end else if (w_wr_tima) begin
         w_tima_next  = wdata;
         w_count_next = '0;
      end else if (w_tick) begin
         w_tima_next = r_tima + 8'd1;
         if ((r_tima == 8'hFF) && (r_count == '0)) begin
            w_count_next = c_reload;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_div   <= c_init_div;
         r_tima  <= 8'h00;
         r_tma   <= 8'h00;
         r_tac   <= 3'b000;
         r_edge  <= 1'b0;
         r_count <= '0;
         r_irq   <= 1'b0;
      end else begin
         r_div   <= w_wr_div ? '0 : (r_div + DIV_WIDTH'(1));
         r_tima  <= w_tima_next;
         r_tma   <= w_tma_next;
         r_tac   <= w_wr_tac ? wdata[2:0] : r_tac;
         r_edge  <= w_sig;
         r_count <= w_count_next;
         r_irq   <= w_irq_next;
      end
   end

   always_comb begin
      rdata = 8'h00;
      case (addr)
         c_addr_div:  rdata = w_div_hi;
         c_addr_tima: rdata = r_tima;
         c_addr_tma:  rdata = r_tma;
         default:     rdata = {5'b11111, r_tac};
      endcase
   end

   assign irq_timer = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_dmg_timer.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmg_timer
// Brief   : scoreboard bench for dmg_timer against a behavioural timer model
// Revision: 1.0 - initial release
// ============================================================================
module tb_dmg_timer;

   localparam int RELOAD_DELAY = 4;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       wr    = 1'b0;
   logic [1:0] addr  = 2'd0;
   logic [7:0] wdata = 8'h00;
   logic [7:0] rdata;
   logic       irq_timer;

   dmg_timer #(
      .DIV_WIDTH   (16),
      .RELOAD_DELAY(RELOAD_DELAY),
      .INITIAL_DIV (0)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .wr       (wr),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .irq_timer(irq_timer)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [1:0] addr;
      logic [7:0] rd;
      logic       irq;
   } exp_t;
   exp_t sb[$];

   // Reference model state: plain integers, one step per clock edge.
   int m_div, m_tima, m_tma, m_tac, m_cnt;
   bit m_prev, m_irq;
   int tap_pos[4] = '{9, 3, 5, 7};

   function automatic void check8(string name, logic [7:0] act, logic [7:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%02h, want 0x%02h", name, act, exp);
   endfunction

   function automatic void check1(string name, logic act, logic exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b, want %b", name, act, exp);
   endfunction

   function automatic void model_step(bit rst, bit w, int a, int d);
      bit sig, tick;
      int tma_n;
      if (rst) begin
         m_div = 0; m_tima = 0; m_tma = 0; m_tac = 0;
         m_cnt = 0; m_prev = 0; m_irq = 0;
         return;
      end
      sig  = ((m_tac & 4) != 0) && (((m_div >> tap_pos[m_tac & 3]) & 1) == 1);
      tick = m_prev && !sig;
      m_prev = sig;
      tma_n = (w && a == 2) ? d : m_tma;
      m_irq = 0;
      if (m_cnt == 1) begin
         m_tima = tma_n;
         m_irq  = 1;
         m_cnt  = 0;
      end else begin
         if (m_cnt > 0) m_cnt--;
         if (w && a == 1) begin
            m_tima = d;
            m_cnt  = 0;
         end else if (tick) begin
            if (m_tima == 255) begin
               m_tima = 0;
               m_cnt  = RELOAD_DELAY;
            end else begin
               m_tima++;
            end
         end
      end
      m_tma = tma_n;
      if (w && a == 3) m_tac = d & 7;
      m_div = (w && a == 0) ? 0 : ((m_div + 1) % 65536);
   endfunction

   function automatic int m_read(int a);
      case (a)
         0:       return (m_div >> 8) & 255;
         1:       return m_tima;
         2:       return m_tma;
         default: return 248 | m_tac;
      endcase
   endfunction

   task automatic cyc(input bit rst, input bit w, input int a, input int d);
      exp_t e;
      int   r;
      @(negedge clk);
      reset = rst;
      wr    = w;
      addr  = a[1:0];
      wdata = d[7:0];
      model_step(rst, w, a, d);
      r      = m_read(a);
      e.addr = a[1:0];
      e.rd   = r[7:0];
      e.irq  = m_irq;
      sb.push_back(e);
   endtask

   task automatic idle(input int a);
      cyc(1'b0, 1'b0, a, 0);
   endtask

   task automatic wreg(input int a, input int d);
      cyc(1'b0, 1'b1, a, d);
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic setup_overflow(input int tma);
      wreg(3, 5);
      wreg(1, 8'hFE);
      wreg(2, tma);
   endtask

   task automatic wait_tima_zero();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         idle(1);
         settle();
         if (rdata == 8'h00) begin
            ok = 1'b1;
            break;
         end
      end
      check1("overflow_seen", ok, 1'b1);
   endtask

   // Monitor: one expected entry per clock edge, compared just after the edge.
   initial begin
      forever begin
         exp_t e;
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check8($sformatf("rdata_addr%0d", e.addr), rdata, e.rd);
            check1("irq", irq_timer, e.irq);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      bit irq_seen;
      int r, a, d;

      // Reset values and free-running divider.
      cyc(1'b1, 1'b0, 0, 0);
      settle();
      check8("reset_div", rdata, 8'h00);
      check1("reset_irq", irq_timer, 1'b0);
      idle(1); settle(); check8("reset_tima", rdata, 8'h00);
      idle(2); settle(); check8("reset_tma", rdata, 8'h00);
      idle(3); settle(); check8("reset_tac", rdata, 8'hF8);
      for (int i = 0; i < 1021; i++) idle(0);
      settle();
      check8("div_after_1024", rdata, 8'h04);
      idle(1); settle(); check8("tima_tac0", rdata, 8'h00);

      // Overflow, 4-cycle zero window, reload and single IRQ.
      setup_overflow(8'h80);
      wait_tima_zero();
      for (int k = 0; k < 3; k++) begin
         idle(1); settle();
         check8("window_zero", rdata, 8'h00);
         check1("window_no_irq", irq_timer, 1'b0);
      end
      idle(1); settle();
      check8("reload_val", rdata, 8'h80);
      check1("irq_pulse", irq_timer, 1'b1);
      idle(1); settle();
      check1("irq_one_cycle", irq_timer, 1'b0);

      // TIMA write inside the window cancels reload and IRQ.
      setup_overflow(8'h80);
      wait_tima_zero();
      idle(1);
      wreg(1, 8'h33);
      settle();
      check8("cancel_tima", rdata, 8'h33);
      irq_seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         idle(1); settle();
         if (irq_timer) irq_seen = 1'b1;
      end
      check1("cancel_no_irq", irq_seen, 1'b0);

      // TMA written on the reload edge is the value reloaded.
      setup_overflow(8'h80);
      wait_tima_zero();
      for (int k = 0; k < 3; k++) idle(1);
      wreg(2, 8'h55);
      settle();
      check1("tma_edge_irq", irq_timer, 1'b1);
      idle(1); settle();
      check8("tma_edge_tima", rdata, 8'h55);
      check1("tma_edge_irq_off", irq_timer, 1'b0);

      // DIV write with tap high gives a glitch tick; with tap low it does not.
      wreg(3, 4);
      wreg(1, 8'h10);
      for (int i = 0; i < 1100; i++) begin
         idle(1);
         if (((m_div >> 9) & 1) == 1 && (m_div & 511) < 16) break;
      end
      idle(1); idle(1); settle();
      check8("pre_glitch_tima", rdata, 8'h10);
      wreg(0, 8'hA5);
      idle(1); idle(1); settle();
      check8("div_glitch_tick", rdata, 8'h11);
      wreg(0, 8'h00);
      idle(1); idle(1); settle();
      check8("div_write_no_tick", rdata, 8'h11);

      // Reset inside the reload window (count == 2).
      setup_overflow(8'h80);
      wait_tima_zero();
      idle(1); idle(1);
      cyc(1'b1, 1'b0, 0, 0);
      settle();
      check8("win_reset_div", rdata, 8'h00);
      idle(1); settle();
      check8("win_reset_tima", rdata, 8'h00);
      irq_seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         idle(1); settle();
         if (irq_timer) irq_seen = 1'b1;
      end
      check1("win_reset_no_irq", irq_seen, 1'b0);

      // Randomized traffic, checked by the monitor against the model.
      for (int i = 0; i < 4000; i++) begin
         r = $urandom_range(0, 199);
         a = $urandom_range(0, 3);
         d = $urandom_range(0, 255);
         if (r == 0) begin
            cyc(1'b1, r[0] ^ d[0], a, d);
         end else if (r < 24) begin
            if (a == 1 && d[0]) d = $urandom_range(240, 255);
            if (a == 3 && d[7:6] != 2'b00) d = $urandom_range(4, 7);
            wreg(a, d);
         end else begin
            idle(a);
         end
      end

      settle();
      settle();
      check8("sb_drained", 8'(sb.size()), 8'h00);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
